// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared external ALU: grants one operation at a time,
// round-robins under contention, returns the result with a valid/ready handshake and counts completions.
module alu_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [2:0]       req0_f,
    input  logic [2:0]       req1_f,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_f,
    input  logic [3:0]       alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_y,
    output logic             rsp_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr;
    logic             r_id;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [2:0]       r_alu_f;
    logic             r_rsp_valid;
    logic [3:0]       r_rsp_y;
    logic             r_rsp_id;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic w_gnt_any;
    logic w_gnt_id;
    logic w_issue;
    logic w_retire;
    logic w_req0_ready;
    logic w_req1_ready;

    // Pointer only breaks ties; a lone requester always wins.
    assign w_gnt_any = req0_valid | req1_valid;
    assign w_gnt_id  = (req0_valid & req1_valid) ? r_ptr : req1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_any) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_issue      = 1'b0;
        w_retire     = 1'b0;
        if (r_state == IDLE) begin
            w_req0_ready = w_gnt_any & ~w_gnt_id;
            w_req1_ready = w_gnt_any &  w_gnt_id;
            w_issue      = w_gnt_any;
        end
        if (r_state == RESP) begin
            w_retire = rsp_ready;
        end
    end

    // Operand latch, result capture and completion counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= 1'b0;
            r_id        <= 1'b0;
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_alu_f     <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= 4'd0;
            r_rsp_id    <= 1'b0;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
        end else begin
            if (w_issue) begin
                r_alu_a <= w_gnt_id ? req1_a : req0_a;
                r_alu_b <= w_gnt_id ? req1_b : req0_b;
                r_alu_f <= w_gnt_id ? req1_f : req0_f;
                r_id    <= w_gnt_id;
                r_ptr   <= ~w_gnt_id;
            end
            if (r_state == EXEC) begin
                r_rsp_y     <= alu_y;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            if (w_retire) begin
                r_rsp_valid <= 1'b0;
                if (r_rsp_id) begin
                    r_cnt1 <= r_cnt1 + CNT_W'(1);
                end else begin
                    r_cnt0 <= r_cnt0 + CNT_W'(1);
                end
            end
        end
    end

    assign req0_ready = w_req0_ready;
    assign req1_ready = w_req1_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_f      = r_alu_f;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_y      = r_rsp_y;
    assign rsp_id     = r_rsp_id;
    assign cnt0       = r_cnt0;
    assign cnt1       = r_cnt1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the shared ALU, tracks grant pointer and counters from the
// arbitration rules, and checks directed plus randomized operations cycle by cycle.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_f, req1_f;
    logic [3:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_f;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_y;
    logic       rsp_id;
    logic [7:0] cnt0, cnt1;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic m_ptr;
    int   m_cnt[2];
    logic [3:0] last_y;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_f(req0_f), .req1_f(req1_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_id(rsp_id),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (f)
            3'd0:    r = ia & ib;
            3'd1:    r = ia | ib;
            3'd2:    r = (ia + ib) % 16;
            3'd3:    r = (ia == ib) ? 1 : 0;
            3'd4:    r = ia & (15 - ib);
            3'd5:    r = ia | (15 - ib);
            3'd6:    r = (ia - ib + 16) % 16;
            default: r = (ia > ib) ? 1 : 0;
        endcase
        return 4'(r);
    endfunction

    assign alu_y = alu_fn(alu_a, alu_b, alu_f);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_reqs();
        req0_valid = 1'($urandom);
        req1_valid = 1'($urandom);
        req0_a = 4'($urandom); req0_b = 4'($urandom); req0_f = 3'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom); req1_f = 3'($urandom);
    endtask

    // Called at a negedge while idle; leaves the bench at the negedge after retirement.
    task automatic run_op(input logic v0, input logic v1,
                          input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] f0,
                          input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] f1,
                          input int stall);
        logic g;
        logic [3:0] ea, eb, ey;
        logic [2:0] ef;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_f = f0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_f = f1;
        rsp_ready  = 1'b0;
        g  = (v0 && v1) ? m_ptr : v1;
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        ef = g ? f1 : f0;
        ey = alu_fn(ea, eb, ef);
        #1;
        chk("grant_ready0", 32'(req0_ready), 32'(!g));
        chk("grant_ready1", 32'(req1_ready), 32'(g));
        @(posedge clk);
        m_ptr = !g;
        @(negedge clk);
        scramble_reqs();
        rsp_ready = 1'($urandom);
        #1;
        chk("exec_alu_a", 32'(alu_a), 32'(ea));
        chk("exec_alu_b", 32'(alu_b), 32'(eb));
        chk("exec_alu_f", 32'(alu_f), 32'(ef));
        chk("exec_rsp_valid", 32'(rsp_valid), 0);
        chk("exec_ready", 32'({req0_ready, req1_ready}), 0);
        rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("resp_valid", 32'(rsp_valid), 1);
        chk("resp_y", 32'(rsp_y), 32'(ey));
        chk("resp_id", 32'(rsp_id), 32'(g));
        chk("resp_ready", 32'({req0_ready, req1_ready}), 0);
        last_y = rsp_y;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            scramble_reqs();
            #1;
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_y", 32'(rsp_y), 32'(ey));
            chk("stall_id", 32'(rsp_id), 32'(g));
            chk("stall_ready", 32'({req0_ready, req1_ready}), 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_cnt[g] = (m_cnt[g] + 1) % 256;
        #1;
        chk("retire_valid", 32'(rsp_valid), 0);
        chk("retire_cnt0", 32'(cnt0), 32'(m_cnt[0]));
        chk("retire_cnt1", 32'(cnt1), 32'(m_cnt[1]));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_y"}, 32'(rsp_y), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_alu_a"}, 32'(alu_a), 0);
        chk({tag, "_alu_b"}, 32'(alu_b), 0);
        chk({tag, "_alu_f"}, 32'(alu_f), 0);
        chk({tag, "_cnt0"}, 32'(cnt0), 0);
        chk({tag, "_cnt1"}, 32'(cnt1), 0);
    endtask

    initial begin
        logic v0, v1, p;
        int   gq[$];
        int   iq[$];
        int   expg[4];

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_f = '0;
        req1_a = '0; req1_b = '0; req1_f = '0;
        rsp_ready = 1'b0;
        m_ptr = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0; last_y = '0;
        #12;
        chk_reset_vals("por");
        chk("por_ready", 32'({req0_ready, req1_ready}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First handshake lands on the first rising edge after reset release.
        run_op(1, 0, 4'd3, 4'd4, 3'b010, 4'd0, 4'd0, 3'd0, 0);
        chk("add_3_4", 32'(last_y), 32'h7);
        run_op(0, 1, 4'd0, 4'd0, 3'd0, 4'd2, 4'd5, 3'b110, 0);
        chk("sub_2_5", 32'(last_y), 32'hd);
        run_op(0, 1, 4'd0, 4'd0, 3'd0, 4'd5, 4'd2, 3'b111, 1);
        chk("gt_5_2", 32'(last_y), 32'h1);
        run_op(0, 1, 4'd0, 4'd0, 3'd0, 4'd9, 4'd9, 3'b011, 2);
        chk("eq_9_9", 32'(last_y), 32'h1);

        run_op(1, 1, 4'($urandom), 4'($urandom), 3'($urandom),
               4'($urandom), 4'($urandom), 3'($urandom), 5);

        for (int k = 0; k < 24; k++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            run_op(v0, v1, 4'($urandom), 4'($urandom), 3'($urandom),
                   4'($urandom), 4'($urandom), 3'($urandom), $urandom_range(0, 3));
        end

        // Continuous contention straight out of reset.
        rst_n = 1'b0;
        m_ptr = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd3; req0_f = 3'b010;
        req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd1; req1_f = 3'b001;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (req0_ready) gq.push_back(0);
            if (req1_ready) gq.push_back(1);
            if (rsp_valid)  iq.push_back(int'(rsp_id));
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        p = m_ptr;
        for (int k = 0; k < 4; k++) begin
            expg[k] = int'(p);
            p = !p;
            m_cnt[expg[k]]++;
        end
        m_ptr = p;
        chk("rr_grant_count", 32'(gq.size()), 4);
        chk("rr_rsp_count", 32'(iq.size()), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < gq.size()) chk("rr_grant_seq", 32'(gq[k]), 32'(expg[k]));
            if (k < iq.size()) chk("rr_rsp_id_seq", 32'(iq[k]), 32'(expg[k]));
        end
        #1;
        chk("rr_cnt0", 32'(cnt0), 32'(m_cnt[0]));
        chk("rr_cnt1", 32'(cnt1), 32'(m_cnt[1]));

        // Reset asserted mid-operation while in EXEC.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd6; req0_f = 3'b001;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        m_ptr = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_rsp", 32'(rsp_valid), 0);
            chk("post_rst_cnt", 32'({cnt1, cnt0}), 0);
        end

        run_op(0, 1, 4'd0, 4'd0, 3'd0, 4'($urandom), 4'($urandom), 3'($urandom), 0);

        // 256 back-to-back req0 operations wrap cnt0.
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_f = 3'b000;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (765) @(posedge clk);
        @(negedge clk);
        #1;
        chk("wrap_cnt0_255", 32'(cnt0), 32'((m_cnt[0] + 255) % 256));
        repeat (3) @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        rsp_ready  = 1'b0;
        m_cnt[0] = (m_cnt[0] + 256) % 256;
        m_ptr = 1'b1;
        #1;
        chk("wrap_cnt0", 32'(cnt0), 32'(m_cnt[0]));
        chk("wrap_cnt1", 32'(cnt1), 32'(m_cnt[1]));

        run_op(1, 1, 4'($urandom), 4'($urandom), 3'($urandom),
               4'($urandom), 4'($urandom), 3'($urandom), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
